bcd_tick_counter: RTL and testbench

Parametrised N-digit BCD counter with a built-in clock prescaler, up/down mode, pause, synchronous clear/load, wrap flagging and optional seven-segment decoding. It is the general replacement for the fixed 3-digit seconds counter on the DE-board front panel. It sits between the board clock and the HEX displays, and its BCD bus also feeds LEDs or downstream logic.

---
 rtl/bcd_tick_pkg.sv | 26 ++
 rtl/bcd_tick_counter_digit.sv | 39 +++
 rtl/bcd_tick_counter.sv | 96 +++++++++
 tb/tb_bcd_tick_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_tick_pkg.sv
// Shared constants and helpers for the BCD tick counter.
package bcd_tick_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SSD_W = 7;

  // Active-low a..g patterns for digits 0..9 (segment a is the MSB)
  localparam logic [SSD_W-1:0] SSD_PATTERN [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100
  };

  localparam logic [SSD_W-1:0] SSD_BLANK = 7'b1111111;

  // Clamp an out-of-range nibble to 9
  function automatic logic [BCD_W-1:0] bcd_sanitise(input logic [BCD_W-1:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Segment lookup; codes above 9 blank the digit
  function automatic logic [SSD_W-1:0] ssd_lookup(input logic [BCD_W-1:0] d);
    if (d > 4'd9) return SSD_BLANK;
    return SSD_PATTERN[d];
  endfunction

endpackage

// File: rtl/bcd_tick_counter_digit.sv
// One BCD digit of the ripple chain: load, or step up/down with carry/borrow out.
module bcd_digit
  import bcd_tick_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o,
  output logic             borrow_o
);

  logic [BCD_W-1:0] digit_q, digit_d;

  // Next digit value: load wins over step
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (step_i) begin
      if (up_i) digit_d = (digit_q == 4'd9) ? '0 : digit_q + 4'd1;
      else      digit_d = (digit_q == '0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  assign digit_o  = digit_q;
  assign carry_o  = step_i &  up_i & (digit_q == 4'd9);
  assign borrow_o = step_i & ~up_i & (digit_q == '0);

endmodule

// File: rtl/bcd_tick_counter.sv
// N-digit BCD counter with prescaler, up/down, pause, clear/load and wrap pulse.
// Define BCD_TICK_SSD_DECODE_EN to build the seven-segment decoder; otherwise HEX is all ones.
module bcd_tick_counter
  import bcd_tick_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned TICK_W   = 26
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
  input  logic                      EN,
  input  logic                      CLR,
  input  logic                      UP,
  input  logic                      LOAD,
  input  logic [BCD_W*DIGITS-1:0]   LOAD_VAL,
  output logic [BCD_W*DIGITS-1:0]   COUNT,
  output logic                      TICK,
  output logic                      WRAP,
  output logic [SSD_W*DIGITS-1:0]   HEX
);

  localparam logic [TICK_W-1:0] P_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]       p_q, p_d;
  logic                    tick_q, wrap_q;
  logic                    load_any;
  logic                    step_ev;
  logic [DIGITS:0]         chain;
  logic [DIGITS-1:0]       carry, borrow;
  logic [BCD_W*DIGITS-1:0] load_val_s;

  assign load_any = CLR | LOAD;
  assign step_ev  = EN & ~load_any & (p_q == P_LAST);

  // Clear is folded into the digit load path as a load of zero
  always_comb begin
    load_val_s = '0;
    if (!CLR) begin
      for (int unsigned i = 0; i < DIGITS; i++)
        load_val_s[BCD_W*i +: BCD_W] = bcd_sanitise(LOAD_VAL[BCD_W*i +: BCD_W]);
    end
  end

  // Prescaler next state: restart on clear/load, hold when paused
  always_comb begin
    p_d = p_q;
    if (load_any)         p_d = '0;
    else if (EN) p_d = (p_q == P_LAST) ? '0 : p_q + TICK_W'(1);
  end

  assign chain[0] = step_ev;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i      (CLOCK_50),
      .rst_ni     (RESET_N),
      .step_i     (chain[g]),
      .up_i       (UP),
      .load_i     (load_any),
      .load_val_i (load_val_s[BCD_W*g +: BCD_W]),
      .digit_o    (COUNT[BCD_W*g +: BCD_W]),
      .carry_o    (carry[g]),
      .borrow_o   (borrow[g])
    );
    assign chain[g+1] = carry[g] | borrow[g];
  end

  // Prescaler and pulse registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      tick_q <= step_ev;
      wrap_q <= chain[DIGITS];
    end
  end

  assign TICK = tick_q;
  assign WRAP = wrap_q;

`ifdef BCD_TICK_SSD_DECODE_EN
  // Combinational seven-segment decode of the count register
  always_comb begin
    HEX = '1;
    for (int unsigned i = 0; i < DIGITS; i++)
      HEX[SSD_W*i +: SSD_W] = ssd_lookup(COUNT[BCD_W*i +: BCD_W]);
  end
`else
  assign HEX = '1;
`endif

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter (DIGITS=3, TICK_DIV=4).
module tb_bcd_tick_counter;

  localparam int DIGITS   = 3;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, clr = 1'b0, up = 1'b1, load = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] count;
  logic        tick, wrap;
  logic [20:0] hex;

  typedef struct {
    logic [11:0] cnt;
    logic        tick;
    logic        wrap;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_val = 0;
  int   m_p = 0;
  int   tick_cnt = 0;

  bcd_tick_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .TICK_W(3)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .EN       (en),
    .CLR      (clr),
    .UP       (up),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .COUNT    (count),
    .TICK     (tick),
    .WRAP     (wrap),
    .HEX      (hex)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_dec(input logic [11:0] b);
    int s;
    int n;
    s = 0;
    for (int i = 2; i >= 0; i--) begin
      n = int'(b[4*i +: 4]);
      if (n > 9) n = 9;
      s = s * 10 + n;
    end
    return s;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0001100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [20:0] exp_hex(input logic [11:0] c);
    logic [20:0] h;
    h = '1;
`ifdef BCD_TICK_SSD_DECODE_EN
    for (int i = 0; i < 3; i++) h[7*i +: 7] = seg(c[4*i +: 4]);
`endif
    return h;
  endfunction

  // Advance the model with the current inputs, push, then compare after the edge
  task automatic cyc();
    exp_t e;
    e.tick = 1'b0;
    e.wrap = 1'b0;
    if (clr) begin
      m_val = 0; m_p = 0;
    end else if (load) begin
      m_val = sat_dec(load_val); m_p = 0;
    end else if (en) begin
      if (m_p == TICK_DIV - 1) begin
        m_p = 0;
        e.tick = 1'b1;
        if (up) begin
          if (m_val == 999) begin m_val = 0; e.wrap = 1'b1; end
          else m_val++;
        end else begin
          if (m_val == 0) begin m_val = 999; e.wrap = 1'b1; end
          else m_val--;
        end
      end else begin
        m_p++;
      end
    end
    e.cnt = to_bcd(m_val);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check_eq("count", 32'(count), 32'(e.cnt));
      check_eq("tick", 32'(tick), 32'(e.tick));
      check_eq("wrap", 32'(wrap), 32'(e.wrap));
      check_eq("hex", 32'(hex), 32'(exp_hex(e.cnt)));
    end
    if (tick) tick_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_tick", 32'(tick), 32'h0);
    check_eq("rst_wrap", 32'(wrap), 32'h0);
    check_eq("rst_hex", 32'(hex), 32'(exp_hex(12'h000)));
    m_val = 0;
    m_p = 0;
    rst_n = 1'b1;
    en = 1'b1;
    up = 1'b1;

    // Free run from reset
    tick_cnt = 0;
    repeat (40) cyc();
    check_eq("ticks40", 32'(tick_cnt), 32'd10);
    check_eq("cnt40", 32'(count), 32'h010);
`ifdef BCD_TICK_SSD_DECODE_EN
    check_eq("hex_d0", 32'(hex[6:0]), 32'(7'b0000001));
    check_eq("hex_d1", 32'(hex[13:7]), 32'(7'b1001111));
`else
    check_eq("hex_blank", 32'(hex), 32'h1FFFFF);
`endif

    // Up wrap
    load = 1'b1; load_val = 12'h998; cyc(); load = 1'b0;
    repeat (8) cyc();
    check_eq("upwrap_cnt", 32'(count), 32'h000);

    // Down borrow and down wrap
    up = 1'b0;
    load = 1'b1; load_val = 12'h100; cyc(); load = 1'b0;
    repeat (4) cyc();
    check_eq("borrow_cnt", 32'(count), 32'h099);
    load = 1'b1; load_val = 12'h000; cyc(); load = 1'b0;
    repeat (4) cyc();
    check_eq("dnwrap_cnt", 32'(count), 32'h999);

    // Sanitised load
    up = 1'b1;
    load = 1'b1; load_val = 12'h5F2; cyc(); load = 1'b0;
    check_eq("sanitise", 32'(count), 32'h592);

    // CLR + LOAD on a step edge
    for (int k = 0; k < 8 && m_p != TICK_DIV - 1; k++) cyc();
    check_eq("align_p3", 32'(m_p), 32'(TICK_DIV - 1));
    clr = 1'b1; load = 1'b1; load_val = 12'h123; cyc();
    check_eq("clr_cnt", 32'(count), 32'h000);
    check_eq("clr_notick", 32'(tick), 32'h0);
    clr = 1'b0; load = 1'b0;
    repeat (4) cyc();

    // Pause at P=2
    for (int k = 0; k < 8 && m_p != 2; k++) cyc();
    check_eq("align_p2", 32'(m_p), 32'd2);
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    repeat (3) cyc();

    // Random mix
    repeat (80) begin
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 9) == 0);
      load_val = 12'($urandom());
      cyc();
    end
    clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;

    // Asynchronous reset between edges
    load = 1'b1; load_val = 12'h457; cyc(); load = 1'b0;
    check_eq("pre_rst", 32'(count), 32'h457);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(count), 32'h0);
    check_eq("arst_tick", 32'(tick), 32'h0);
    check_eq("arst_wrap", 32'(wrap), 32'h0);
    check_eq("arst_hex", 32'(hex), 32'(exp_hex(12'h000)));
    m_val = 0;
    m_p = 0;
    #1 rst_n = 1'b1;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
